// File: rtl/spi_pkg.sv
// Purpose : shared constants, frame field positions and FSM state type for the SPI target.
// Latency : n/a (declarations only).
// Backpressure: n/a; no ports.
// Frame layout, MSB first on MOSI: {Wr, ADDR[7:0], DATA[7:0]}.
package spi_pkg;

   localparam int SPI_ADDR_W = 8;
   localparam int SPI_DATA_W = 8;
   localparam int FRAME_W    = 1 + SPI_ADDR_W + SPI_DATA_W;

   // Bit positions within the 17-bit frame
   localparam int WR_BIT   = 16;
   localparam int ADDR_MSB = 15;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } spi_slv_state_t;

endpackage

// File: rtl/spi_regfile.sv
// Purpose : NUM_REGS x DATA_WIDTH register file, one write port, two async read ports.
// Latency : write visible on read ports the cycle after i_we; reads are combinational.
// Backpressure: none; a write is accepted on every cycle i_we is high.
// Ports: SCLK/resetn clock and async active-low reset; i_we/i_waddr/i_wdata write port;
//        i_raddr_a/o_rdata_a frame read port; i_raddr_b/o_rdata_b debug read port.
//        Unmapped addresses (>= NUM_REGS) read as 0 and ignore writes.
module spi_regfile
   import spi_pkg::*;
#(
   parameter int ADDR_WIDTH = SPI_ADDR_W,
   parameter int DATA_WIDTH = SPI_DATA_W,
   parameter int NUM_REGS   = 16
) (
   input  logic                  SCLK,
   input  logic                  resetn,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr_a,
   output logic [DATA_WIDTH-1:0] o_rdata_a,
   input  logic [ADDR_WIDTH-1:0] i_raddr_b,
   output logic [DATA_WIDTH-1:0] o_rdata_b
);

   localparam int                  IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH + 1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   // Full-width unsigned compare so high addresses never alias onto low registers
   function automatic logic f_mapped(input logic [ADDR_WIDTH-1:0] a);
      return ({1'b0, a} < LP_NUM_REGS);
   endfunction

   always_ff @(posedge SCLK or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && f_mapped(i_waddr)) begin
         r_regs[i_waddr[IDX_W-1:0]] <= i_wdata;
      end
   end

   assign o_rdata_a = f_mapped(i_raddr_a) ? r_regs[i_raddr_a[IDX_W-1:0]] : '0;
   assign o_rdata_b = f_mapped(i_raddr_b) ? r_regs[i_raddr_b[IDX_W-1:0]] : '0;

endmodule

// File: rtl/spi_slave_regfile.sv
// Purpose : SPI target; deserialises {Wr, ADDR, DATA} frames into a local register file, returns reads on MISO LSB first.
// Latency : write/pulses appear the cycle after the final frame edge; read data bit 0 on MISO the cycle after the last address bit.
// Backpressure: none; frames accepted back-to-back while ss_n is held low, ss_n high mid-frame aborts.
// Ports: SCLK/resetn clock and async active-low reset; ss_n/MOSI/MISO serial link;
//        reg_wr/reg_waddr/reg_wdata write notification; frame_done/frame_abort/addr_err status pulses;
//        dbg_addr/dbg_rdata combinational debug read.
// Build option: define SPI_SLAVE_WR_ECHO_EN to echo the pre-write register value on MISO during write frames.
module spi_slave_regfile
   import spi_pkg::*;
#(
   parameter int ADDR_WIDTH  = SPI_ADDR_W,
   parameter int DATA_WIDTH  = SPI_DATA_W,
   parameter int NUM_REGS    = 16,
   parameter int COUNT_WIDTH = 3
) (
   input  logic                  SCLK,
   input  logic                  resetn,
   input  logic                  ss_n,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  reg_wr,
   output logic [ADDR_WIDTH-1:0] reg_waddr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   output logic                  frame_done,
   output logic                  frame_abort,
   output logic                  addr_err,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_rdata
);

   localparam logic [COUNT_WIDTH-1:0] LP_ADDR_LAST = COUNT_WIDTH'(ADDR_WIDTH - 1);
   localparam logic [COUNT_WIDTH-1:0] LP_DATA_LAST = COUNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [ADDR_WIDTH:0]    LP_NUM_REGS  = (ADDR_WIDTH + 1)'(NUM_REGS);

   spi_slv_state_t          r_state;
   logic                    r_wr;
   logic [ADDR_WIDTH-1:0]   r_addr_sr;
   logic [DATA_WIDTH-2:0]   r_data_sr;   // last data bit comes straight from MOSI
   logic [COUNT_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0]   r_rd_sr;

   logic [ADDR_WIDTH-1:0]   w_addr_next;
   logic [DATA_WIDTH-1:0]   w_data_next;
   logic [DATA_WIDTH-1:0]   w_rd_data;
   logic                    w_addr_mapped;
   logic                    w_frame_end;
   logic                    w_reg_we;
   logic                    w_miso_en;

   assign w_addr_next   = {r_addr_sr[ADDR_WIDTH-2:0], MOSI};
   assign w_data_next   = {r_data_sr, MOSI};
   assign w_addr_mapped = ({1'b0, r_addr_sr} < LP_NUM_REGS);
   assign w_frame_end   = (r_state == DATA) && !ss_n && (r_cnt == LP_DATA_LAST);
   assign w_reg_we      = w_frame_end && r_wr && w_addr_mapped;

`ifdef SPI_SLAVE_WR_ECHO_EN
   assign w_miso_en = 1'b1;
`else
   assign w_miso_en = !r_wr;
`endif

   // rd_sr[0] carries data bit k during DATA cycle k; silent outside DATA
   assign MISO = (r_state == DATA) && w_miso_en && r_rd_sr[0];

   spi_regfile #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_regfile (
      .SCLK      (SCLK),
      .resetn    (resetn),
      .i_we      (w_reg_we),
      .i_waddr   (r_addr_sr),
      .i_wdata   (w_data_next),
      .i_raddr_a (w_addr_next),
      .o_rdata_a (w_rd_data),
      .i_raddr_b (dbg_addr),
      .o_rdata_b (dbg_rdata)
   );

   always_ff @(posedge SCLK or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_wr        <= 1'b0;
         r_addr_sr   <= '0;
         r_data_sr   <= '0;
         r_cnt       <= '0;
         r_rd_sr     <= '0;
         reg_wr      <= 1'b0;
         reg_waddr   <= '0;
         reg_wdata   <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         reg_wr      <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         addr_err    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!ss_n) begin
                  r_wr    <= MOSI;
                  r_cnt   <= '0;
                  r_state <= ADDR;
               end
            end
            ADDR: begin
               if (ss_n) begin
                  r_state     <= IDLE;
                  frame_abort <= 1'b1;
               end else begin
                  r_addr_sr <= w_addr_next;
                  r_cnt     <= r_cnt + 1'b1;
                  if (r_cnt == LP_ADDR_LAST) begin
                     // Loaded for every frame; MISO gating decides whether it is driven
                     r_rd_sr <= w_rd_data;
                     r_cnt   <= '0;
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (ss_n) begin
                  r_state     <= IDLE;
                  frame_abort <= 1'b1;
               end else begin
                  r_data_sr <= w_data_next[DATA_WIDTH-2:0];
                  r_rd_sr   <= {1'b0, r_rd_sr[DATA_WIDTH-1:1]};
                  r_cnt     <= r_cnt + 1'b1;
                  if (w_frame_end) begin
                     r_state    <= IDLE;
                     frame_done <= 1'b1;
                     if (!w_addr_mapped) begin
                        addr_err <= 1'b1;
                     end else if (r_wr) begin
                        reg_wr    <= 1'b1;
                        reg_waddr <= r_addr_sr;
                        reg_wdata <= w_data_next;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
